// File: rtl/divclk_prog.sv
// rtl/divclk_prog.sv - runtime-programmable integer clock divider with tick strobe
module divclk_prog #(
  parameter int DIV_W       = 16,
  parameter int DIV_DEFAULT = 9
) (
  input  logic             iclk,
  input  logic             rst,
  input  logic             en,
  input  logic             sync,
  input  logic             div_wr,
  input  logic [DIV_W-1:0] div_in,
  output logic             oclk,
  output logic             tick,
  output logic [DIV_W-1:0] div_cur,
  output logic             div_pend
);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  localparam logic [DIV_W-1:0] DIV_RST = DIV_W'(DIV_DEFAULT);
  localparam logic [DIV_W-1:0] ONE     = DIV_W'(1);

  state_t           state, state_n;
  logic [DIV_W-1:0] cnt, cnt_n;
  logic [DIV_W-1:0] div_cur_n;
  logic [DIV_W-1:0] div_nxt, div_nxt_n;
  logic             div_pend_n;

  logic [DIV_W-1:0] div_in_cl;
  logic [DIV_W-1:0] last_ph;
  logic             boundary;
  logic [DIV_W:0]   half_n;
  logic             oclk_n;
  logic             tick_n;

  // A zero divisor would never wrap, so it is treated as divide-by-one.
  assign div_in_cl = (div_in == '0) ? ONE : div_in;
  assign last_ph   = div_cur - ONE;
  // sync restarts the period even mid-way; the natural wrap is the other boundary.
  assign boundary  = sync || (cnt == last_ph);

  // State register: idle/run, cleared asynchronously.
  always_ff @(posedge iclk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_n;
    end
  end

  // Next-state, phase counter and divisor bookkeeping.
  always_comb begin
    state_n    = state;
    cnt_n      = cnt;
    div_cur_n  = div_cur;
    div_nxt_n  = div_nxt;
    div_pend_n = div_pend;
    case (state)
      ST_IDLE: begin
        // While stopped there is no period to protect, so writes apply at once.
        if (div_wr) begin
          div_cur_n = div_in_cl;
        end
        cnt_n = '0;
        if (en) begin
          state_n = ST_RUN;
        end
      end
      ST_RUN: begin
        if (!en) begin
          // Stopping truncates the period; a write here still waits for a boundary.
          state_n = ST_IDLE;
          cnt_n   = '0;
          if (div_wr) begin
            div_nxt_n  = div_in_cl;
            div_pend_n = 1'b1;
          end
        end else if (boundary) begin
          cnt_n = '0;
          if (div_wr) begin
            // A write landing on the boundary itself wins over any older pending value.
            div_cur_n  = div_in_cl;
            div_nxt_n  = div_in_cl;
            div_pend_n = 1'b0;
          end else if (div_pend) begin
            div_cur_n  = div_nxt;
            div_pend_n = 1'b0;
          end
        end else begin
          cnt_n = cnt + ONE;
          if (div_wr) begin
            div_nxt_n  = div_in_cl;
            div_pend_n = 1'b1;
          end
        end
      end
      default: begin
        state_n = ST_IDLE;
        cnt_n   = '0;
      end
    endcase

    // Outputs are decoded from the next state so the registered copies line up
    // with the phase counter in the cycle they are visible.
    half_n = ({1'b0, div_cur_n} + (DIV_W+1)'(1)) >> 1;
    oclk_n = (state_n == ST_RUN) && ({1'b0, cnt_n} < half_n);
    tick_n = (state_n == ST_RUN) && (cnt_n == (div_cur_n - ONE));
  end

  // Datapath and registered outputs; reset aborts the period and drops any pending divisor.
  always_ff @(posedge iclk or posedge rst) begin
    if (rst) begin
      cnt      <= '0;
      div_cur  <= DIV_RST;
      div_nxt  <= DIV_RST;
      div_pend <= 1'b0;
      oclk     <= 1'b0;
      tick     <= 1'b0;
    end else begin
      cnt      <= cnt_n;
      div_cur  <= div_cur_n;
      div_nxt  <= div_nxt_n;
      div_pend <= div_pend_n;
      oclk     <= oclk_n;
      tick     <= tick_n;
    end
  end

endmodule

// File: tb/tb_divclk_prog.sv
// tb/tb_divclk_prog.sv - self-checking bench for divclk_prog
module tb_divclk_prog;

  localparam int DIV_W       = 16;
  localparam int DIV_DEFAULT = 9;

  logic             iclk   = 1'b0;
  logic             rst    = 1'b1;
  logic             en     = 1'b0;
  logic             sync   = 1'b0;
  logic             div_wr = 1'b0;
  logic [DIV_W-1:0] div_in = '0;
  logic             oclk;
  logic             tick;
  logic [DIV_W-1:0] div_cur;
  logic             div_pend;

  int errors = 0;
  int checks = 0;
  bit chk_on = 1'b0;

  // Reference: running flag, phase within period, divisor in use, queued divisor.
  bit m_run  = 1'b0;
  int m_ph   = 0;
  int m_n    = DIV_DEFAULT;
  int m_nn   = DIV_DEFAULT;
  bit m_pend = 1'b0;

  divclk_prog #(.DIV_W(DIV_W), .DIV_DEFAULT(DIV_DEFAULT)) dut (
    .iclk    (iclk),
    .rst     (rst),
    .en      (en),
    .sync    (sync),
    .div_wr  (div_wr),
    .div_in  (div_in),
    .oclk    (oclk),
    .tick    (tick),
    .div_cur (div_cur),
    .div_pend(div_pend)
  );

  always #5 iclk = ~iclk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit exp_oclk();
    return m_run && (m_ph < (m_n + 1) / 2);
  endfunction

  function automatic bit exp_tick();
    return m_run && (m_ph == m_n - 1);
  endfunction

  task automatic model_step();
    int v;
    bit at_end;
    v = (div_in == 0) ? 1 : int'(div_in);
    if (!m_run) begin
      if (div_wr) m_n = v;
      if (en) begin
        m_run = 1'b1;
        m_ph  = 0;
      end
    end else if (!en) begin
      m_run = 1'b0;
      m_ph  = 0;
      if (div_wr) begin
        m_nn   = v;
        m_pend = 1'b1;
      end
    end else begin
      at_end = sync || (m_ph == m_n - 1);
      if (at_end) begin
        if (div_wr) m_n = v;
        else if (m_pend) m_n = m_nn;
        m_pend = 1'b0;
        m_ph   = 0;
      end else begin
        m_ph = m_ph + 1;
        if (div_wr) begin
          m_nn   = v;
          m_pend = 1'b1;
        end
      end
    end
  endtask

  // Reference advances on every active edge, and clears on reset at once.
  initial begin
    forever begin
      @(posedge iclk or posedge rst);
      if (rst) begin
        m_run  = 1'b0;
        m_ph   = 0;
        m_n    = DIV_DEFAULT;
        m_nn   = DIV_DEFAULT;
        m_pend = 1'b0;
      end else begin
        model_step();
      end
    end
  end

  // Cycle-by-cycle comparison against the reference, away from the active edge.
  always @(negedge iclk) begin
    if (chk_on) begin
      check("model oclk", oclk, exp_oclk());
      check("model tick", tick, exp_tick());
      check("model div_cur", div_cur, m_n);
      check("model div_pend", div_pend, m_pend);
    end
  end

  task automatic nxt();
    @(posedge iclk);
    #1;
  endtask

  task automatic samp_chk(input string name, input int n, input logic [31:0] po, input logic [31:0] pt);
    for (int i = 0; i < n; i++) begin
      @(negedge iclk);
      check({name, " oclk"}, oclk, po[n-1-i]);
      check({name, " tick"}, tick, pt[n-1-i]);
    end
  endtask

  initial begin
    int highs;
    int ticks;
    int r;
    @(posedge iclk);
    #1;
    check("reset oclk", oclk, 0);
    check("reset tick", tick, 0);
    check("reset div_cur", div_cur, 9);
    check("reset div_pend", div_pend, 0);
    chk_on = 1'b1;
    @(posedge iclk);
    #1;
    rst = 1'b0;
    en  = 1'b1;

    // Default divide-by-9: 5 high, 4 low, tick on the 4th low cycle.
    samp_chk("t1", 19, 32'b0111110000111110000, 32'b0000000001000000001);
    check("t1 div_cur", div_cur, 9);

    // Write 4 at phase 3; it waits for the natural wrap.
    nxt();
    repeat (3) nxt();
    div_wr = 1'b1;
    div_in = 16'd4;
    nxt();
    div_wr = 1'b0;
    check("t2 pend set", div_pend, 1);
    check("t2 cur held", div_cur, 9);
    samp_chk("t2", 13, 32'b1000011001100, 32'b0000100010001);
    check("t2 pend clr", div_pend, 0);
    check("t2 div_cur", div_cur, 4);

    // Idle write of 0 clamps to 1; then 2 gives plain alternation.
    nxt();
    en = 1'b0;
    nxt();
    div_wr = 1'b1;
    div_in = 16'd0;
    nxt();
    div_wr = 1'b0;
    check("t3 clamp", div_cur, 1);
    check("t3 pend", div_pend, 0);
    en = 1'b1;
    samp_chk("t3 n1", 5, 32'b01111, 32'b01111);
    nxt();
    div_wr = 1'b1;
    div_in = 16'd2;
    samp_chk("t3 last1", 1, 32'b1, 32'b1);
    nxt();
    div_wr = 1'b0;
    samp_chk("t3 n2", 4, 32'b1010, 32'b0101);

    // Reset with a divisor pending discards it and returns to default.
    nxt();
    div_wr = 1'b1;
    div_in = 16'd3;
    nxt();
    div_wr = 1'b0;
    check("t4 pend", div_pend, 1);
    check("t4 cur", div_cur, 2);
    rst = 1'b1;
    #2;
    check("t4 rst oclk", oclk, 0);
    check("t4 rst tick", tick, 0);
    check("t4 rst div_cur", div_cur, 9);
    check("t4 rst pend", div_pend, 0);
    nxt();
    rst = 1'b0;
    samp_chk("t4 restart", 10, 32'b0111110000, 32'b0000000001);

    // Switch to 7, then sync at phase 5: restart with no tick, then a full period.
    nxt();
    div_wr = 1'b1;
    div_in = 16'd7;
    nxt();
    div_wr = 1'b0;
    repeat (8) nxt();
    check("t5 div_cur", div_cur, 7);
    repeat (5) nxt();
    sync = 1'b1;
    samp_chk("t5 pre", 1, 32'b0, 32'b0);
    nxt();
    sync = 1'b0;
    samp_chk("t5 post", 7, 32'b1111000, 32'b0000001);

    // Randomised traffic; the reference checks every cycle.
    for (int i = 0; i < 3000; i++) begin
      nxt();
      rst    = 1'b0;
      en     = ($urandom_range(0, 19) != 0);
      sync   = ($urandom_range(0, 9) == 0);
      div_wr = ($urandom_range(0, 7) == 0);
      r      = int'($urandom_range(0, 15));
      div_in = (r == 15) ? 16'd0 : 16'(r);
      if ($urandom_range(0, 399) == 0) begin
        #3;
        rst = 1'b1;
      end
    end

    // Largest divisor: one full period of 65535 cycles.
    nxt();
    rst    = 1'b1;
    en     = 1'b0;
    sync   = 1'b0;
    div_wr = 1'b0;
    nxt();
    rst    = 1'b0;
    div_wr = 1'b1;
    div_in = 16'hFFFF;
    nxt();
    div_wr = 1'b0;
    check("max div_cur", div_cur, 32'hFFFF);
    en = 1'b1;
    @(negedge iclk);
    highs = 0;
    ticks = 0;
    for (int i = 0; i < 65535; i++) begin
      @(negedge iclk);
      if (oclk) highs++;
      if (tick) ticks++;
    end
    check("max highs", highs, 32768);
    check("max ticks", ticks, 1);
    check("max last tick", tick, 1);
    @(negedge iclk);
    check("max wrap oclk", oclk, 1);

    chk_on = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
